// File: rtl/midi_voice_parser.sv
// midi_voice_parser: MIDI byte stream to monophonic note/velocity/gate.
// It handles running status, ignores interleaved real-time bytes, and gives
// the last note played priority.
// Optional feature macro MIDI_PITCHBEND_EN: when defined, 0xEn messages drive
// the bend/bend_valid ports. When undefined, those ports do not exist and
// 0xEn is consumed silently.
`timescale 1ns/1ps
module midi_voice_parser #(
    parameter int CHANNEL = 0,
    parameter int OMNI    = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        wvalid,
    input  logic [7:0]  word,
    output logic        note_valid,
    output logic [6:0]  note,
    output logic [6:0]  velocity,
    output logic        gate
`ifdef MIDI_PITCHBEND_EN
    ,
    output logic [13:0] bend,
    output logic        bend_valid
`endif
);

    typedef enum logic [1:0] {IDLE, WAIT_D1, WAIT_D2} state_t;
    typedef enum logic [1:0] {K_ON, K_OFF, K_BEND}    kind_t;
    typedef struct packed {
        kind_t      kind;
        logic [6:0] d1;
        logic [6:0] d2;
    } msg_t;

    state_t     state, state_d;
    logic [3:0] stype;      // running-status message type (upper nibble)
    logic       len1;       // running status is a one-data-byte message
    logic       accept;     // running status is a supported type on our channel
    logic [6:0] d1;
    logic       take_status, clear_status, latch_d1, complete;
    logic       status_ok;
    logic [6:0] c_d1, c_d2;
    msg_t       msg_d, msg;
    logic       msg_vld;

    // Next state and byte classification
    always_comb begin
        state_d      = state;
        take_status  = 1'b0;
        clear_status = 1'b0;
        latch_d1     = 1'b0;
        complete     = 1'b0;
        if (wvalid) begin
            if (word[7:3] == 5'b11111) begin
                // real-time byte: invisible to the parser
                state_d = state;
            end else if (word[7:4] == 4'hF) begin
                state_d      = IDLE;
                clear_status = 1'b1;
            end else if (word[7]) begin
                state_d     = WAIT_D1;
                take_status = 1'b1;
            end else begin
                case (state)
                    WAIT_D1: begin
                        latch_d1 = 1'b1;
                        if (len1) complete = 1'b1;
                        else      state_d  = WAIT_D2;
                    end
                    WAIT_D2: begin
                        complete = 1'b1;
                        state_d  = WAIT_D1;
                    end
                    default: state_d = state;
                endcase
            end
        end
    end

    // Status acceptance and decode of the message completing this cycle
    always_comb begin
        status_ok = (word[7:4] == 4'h8) || (word[7:4] == 4'h9);
`ifdef MIDI_PITCHBEND_EN
        status_ok = status_ok || (word[7:4] == 4'hE);
`endif
        status_ok = status_ok && ((OMNI != 0) || (word[3:0] == 4'(CHANNEL)));

        c_d1 = len1 ? word[6:0] : d1;
        c_d2 = len1 ? 7'd0 : word[6:0];
        msg_d.d1 = c_d1;
        msg_d.d2 = c_d2;
        if (stype == 4'hE)                         msg_d.kind = K_BEND;
        else if (stype == 4'h9 && c_d2 != 7'd0)    msg_d.kind = K_ON;
        else                                       msg_d.kind = K_OFF;
    end

    // Parser state, running status and first data byte
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            stype  <= 4'h0;
            len1   <= 1'b0;
            accept <= 1'b0;
            d1     <= 7'd0;
        end else begin
            state <= state_d;
            if (take_status) begin
                stype  <= word[7:4];
                len1   <= (word[7:4] == 4'hC) || (word[7:4] == 4'hD);
                accept <= status_ok;
            end else if (clear_status) begin
                accept <= 1'b0;
            end
            if (latch_d1) d1 <= word[6:0];
        end
    end

    // Completed accepted message registered; outputs act on it next edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            msg_vld <= 1'b0;
            msg     <= '0;
        end else begin
            msg_vld <= complete && accept;
            msg     <= msg_d;
        end
    end

    // Voice outputs: last-note priority, note-off only releases the held note
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            note_valid <= 1'b0;
            note       <= 7'd0;
            velocity   <= 7'd0;
            gate       <= 1'b0;
`ifdef MIDI_PITCHBEND_EN
            bend       <= 14'h2000;
            bend_valid <= 1'b0;
`endif
        end else begin
            note_valid <= 1'b0;
`ifdef MIDI_PITCHBEND_EN
            bend_valid <= 1'b0;
`endif
            if (msg_vld) begin
                case (msg.kind)
                    K_ON: begin
                        note       <= msg.d1;
                        velocity   <= msg.d2;
                        gate       <= 1'b1;
                        note_valid <= 1'b1;
                    end
                    K_OFF: begin
                        if (gate && msg.d1 == note) begin
                            gate       <= 1'b0;
                            note_valid <= 1'b1;
                        end
                    end
`ifdef MIDI_PITCHBEND_EN
                    K_BEND: begin
                        bend       <= {msg.d2, msg.d1};
                        bend_valid <= 1'b1;
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_midi_voice_parser.sv
// Scoreboard bench for midi_voice_parser (CHANNEL=0, OMNI=0).
`timescale 1ns/1ps
module tb_midi_voice_parser;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       wvalid = 1'b0;
    logic [7:0] word = 8'h00;
    logic       note_valid;
    logic [6:0] note, velocity;
    logic       gate;
`ifdef MIDI_PITCHBEND_EN
    logic [13:0] bend;
    logic        bend_valid;
`endif

    midi_voice_parser #(.CHANNEL(0), .OMNI(0)) dut (
        .clk(clk), .reset_n(reset_n), .wvalid(wvalid), .word(word),
        .note_valid(note_valid), .note(note), .velocity(velocity), .gate(gate)
`ifdef MIDI_PITCHBEND_EN
        , .bend(bend), .bend_valid(bend_valid)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int n;
        int v;
        int g;
        int cyc;
    } exp_t;

    exp_t q[$];
    int   bq_val[$];
    int   bq_cyc[$];
    int   cyc = 0;
    int   last_cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // one byte, one cycle strobe; back-to-back calls give consecutive strobes
    task automatic send(input logic [7:0] b);
        wvalid = 1'b1;
        word   = b;
        @(posedge clk);
        #1;
        last_cyc = cyc;
        wvalid = 1'b0;
    endtask

    task automatic expect_note(input int n, input int v, input int g);
        exp_t e;
        e.n = n; e.v = v; e.g = g; e.cyc = last_cyc + 1;
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every note_valid pulse must match the next expected update
    always @(negedge clk) begin
        if (note_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_note_valid", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("note", int'(note), e.n);
                chk("velocity", int'(velocity), e.v);
                chk("gate", int'(gate), e.g);
                chk("note_valid_cycle", cyc, e.cyc);
            end
        end
`ifdef MIDI_PITCHBEND_EN
        if (bend_valid) begin
            if (bq_val.size() == 0) begin
                chk("unexpected_bend_valid", 1, 0);
            end else begin
                chk("bend", int'(bend), bq_val.pop_front());
                chk("bend_valid_cycle", cyc, bq_cyc.pop_front());
            end
        end
`endif
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        idle(2);
        chk("rst_note", int'(note), 0);
        chk("rst_velocity", int'(velocity), 0);
        chk("rst_gate", int'(gate), 0);
        chk("rst_note_valid", int'(note_valid), 0);
`ifdef MIDI_PITCHBEND_EN
        chk("rst_bend", int'(bend), 'h2000);
        chk("rst_bend_valid", int'(bend_valid), 0);
`endif
        reset_n = 1'b1;
        idle(2);

        // basic note-on
        send(8'h90); send(8'h3C); send(8'h64); expect_note(60, 100, 1);
        // running status note-on, then note-off by velocity 0
        send(8'h3E); send(8'h50); expect_note(62, 80, 1);
        send(8'h3E); send(8'h00); expect_note(62, 80, 0);
        idle(3);
        chk("held_note_after_off", int'(note), 62);
        chk("gate_after_off", int'(gate), 0);

        // real-time bytes interleaved
        send(8'h90); send(8'hF8); send(8'h40); send(8'hFE); send(8'h7F);
        expect_note(64, 127, 1);
        idle(2);

        // filtering: other channel, program change, mismatched note-off
        send(8'h91); send(8'h3C); send(8'h64);
        send(8'hC0); send(8'h05); send(8'h3C);
        send(8'h90); send(8'h3C); send(8'h64); expect_note(60, 100, 1);
        send(8'h80); send(8'h3D); send(8'h00);
        idle(3);
        chk("gate_after_wrong_off", int'(gate), 1);
        send(8'h80); send(8'h3C); send(8'h40); expect_note(60, 100, 0);
        idle(2);

        // status in WAIT_D2 aborts the partial message
        send(8'h90); send(8'h3C); send(8'h91); send(8'h3C); send(8'h64);
        send(8'h90); send(8'h3C); send(8'h90); send(8'h3D); send(8'h64);
        expect_note(61, 100, 1);
        idle(3);

        // asynchronous reset mid-message
        send(8'h90); send(8'h3C);
        #2 reset_n = 1'b0;
        #1;
        chk("areset_note", int'(note), 0);
        chk("areset_velocity", int'(velocity), 0);
        chk("areset_gate", int'(gate), 0);
`ifdef MIDI_PITCHBEND_EN
        chk("areset_bend", int'(bend), 'h2000);
`endif
        idle(1);
        #2 reset_n = 1'b1;
        idle(2);
        send(8'h64);                                  // IDLE: ignored
        send(8'h90); send(8'h3C); send(8'hF0); send(8'h64);
        idle(3);
        chk("gate_after_sysex_abort", int'(gate), 0);
        chk("note_after_sysex_abort", int'(note), 0);

        // pitch bend (consumed silently without the feature)
        send(8'hE0); send(8'h7F); send(8'h7F);
`ifdef MIDI_PITCHBEND_EN
        bq_val.push_back('h3FFF); bq_cyc.push_back(last_cyc + 1);
`endif
        send(8'h90); send(8'h3C); send(8'h64); expect_note(60, 100, 1);
        idle(4);

        chk("scoreboard_drained", q.size(), 0);
        chk("bend_scoreboard_drained", bq_val.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
